uart_img_loader: RTL and testbench
==================================

# uart_img_loader

Frame loader that fills the 24-bit image memory from the UART receive FIFO. It pops received bytes, packs each group of three bytes (R, G, B) into one 24-bit pixel, and writes pixels to consecutive addresses from 0 up to `PIXEL_COUNT-1`. It sits upstream of the grayscale transmit path: it drives the write port of the image RAM that the filter/UART-transmit stage later reads.

## Interface

Parameters:
- `ADDR_BITS`, 13: width of the memory address.
- `PIXEL_COUNT`, 6767: pixels per frame. Last written address is `PIXEL_COUNT-1`.
- `TIMEOUT_CYCLES`, 1000000: inter-byte idle limit. Used only when `LOADER_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low.
- `start` in 1: arms a frame load when sampled high in IDLE or DONE.
- `rx_empty` in 1: UART RX FIFO empty flag.
- `r_data` in 8: UART RX FIFO head byte; valid while `rx_empty`=0.
- `rd_uart` out 1: FIFO pop strobe, one cycle per byte consumed.
- `mem_we` out 1: RAM write enable, one-cycle pulse per pixel.
- `mem_addr` out ADDR_BITS: RAM write address.
- `mem_di` out 24: RAM write data as {R,G,B}.
- `busy` out 1: high from accepted `start` until the last pixel write.
- `done` out 1: high after the full frame is written; held until the next `start` or reset.
- `err` out 1: one-cycle pulse when a partial pixel is discarded on timeout. Tied 0 when `LOADER_TIMEOUT_EN` is not defined.

## Operation

- States:
  - IDLE: waits for `start`.
  - RECV: pops bytes until one pixel is assembled.
  - WRITE: pulses `mem_we` for one cycle.
  - DONE: frame complete; waits for `start`.
- IDLE/DONE + `start`=1 → RECV. On this transition: `mem_addr`←0, byte index←0, `done`←0, `busy`←1.
- RECV, `rx_empty`=0:
  - `rd_uart`=1 combinationally in that same cycle; `r_data` is captured on that edge.
  - Byte index 0 → `mem_di[23:16]`, 1 → `[15:8]`, 2 → `[7:0]`.
  - After index 2 is captured: byte index←0 and next state is WRITE.
- RECV, `rx_empty`=1: no pop; state and registers hold.
- WRITE:
  - `mem_we`=1, `rd_uart`=0; `mem_addr` and `mem_di` are stable for the whole cycle.
  - If `mem_addr`==`PIXEL_COUNT-1`: go to DONE, `done`←1, `busy`←0, `mem_addr` holds.
  - Otherwise: `mem_addr`←`mem_addr`+1 and go to RECV.
- `start` while `busy`=1 is ignored.
- Bytes arriving in IDLE or DONE are not popped; they stay in the FIFO.
- `rd_uart` is never asserted while `rx_empty`=1. `mem_we` is never high outside WRITE.
- `mem_addr` never exceeds `PIXEL_COUNT-1`; there is no wrap past the frame end.
- Reset (`reset`=0 at a rising edge) in any state:
  - State→IDLE; any partial pixel is discarded.
  - All outputs go to reset values: `rd_uart`=0, `mem_we`=0, `mem_addr`=0, `mem_di`=0, `busy`=0, `done`=0, `err`=0.

## Timing

- Pop to capture: the byte is registered on the edge that ends the `rd_uart` cycle.
- Third pop to write: `mem_we` is high in the cycle immediately after the third `rd_uart` cycle.
- Maximum throughput: one pixel per 4 cycles (3 pops plus 1 write). Back-to-back pops occur when `rx_empty` stays 0.
- Last write to DONE: `done`=1 and `busy`=0 in the cycle after the final `mem_we`.
- `start` to first possible pop: 1 cycle.

## Configuration

- `LOADER_TIMEOUT_EN` defined:
  - An idle counter runs in RECV while the byte index is nonzero. It clears on every pop.
  - When it reaches `TIMEOUT_CYCLES`: byte index←0, the partial pixel is dropped, `mem_addr` is unchanged, and `err` pulses for 1 cycle.
  - This resynchronises the loader to pixel boundaries after a lost byte.
- `LOADER_TIMEOUT_EN` undefined: no counter; the loader waits indefinitely mid-pixel; `err` is constant 0.

## Test plan

- Reset, `start`, then feed 0x11, 0x22, 0x33 → three single-cycle `rd_uart` pulses, then `mem_we`=1 with `mem_addr`=0 and `mem_di`=0x112233 in the next cycle.
- `start`, then hold `rx_empty`=1 for 100 cycles → `rd_uart`=0 and `mem_we`=0 throughout; `busy`=1, `done`=0.
- `PIXEL_COUNT`=4, feed 12 bytes 0x00..0x0B plus 3 extra → writes at addrs 0..3 with data 0x000102, 0x030405, 0x060708, 0x090A0B; `done`=1 one cycle after the 4th write; the 3 extra bytes are not popped.
- Reset low for 1 cycle after 2 bytes of a pixel → all outputs at reset values. Then `start` and 0xA1, 0xB2, 0xC3 → write at addr 0 with 0xA1B2C3.
- Pulse `start` at the 5th cycle of a load → no restart; addresses continue in sequence.
- With `LOADER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: one byte 0x55, 16 idle cycles, then 0xAA, 0xBB, 0xCC → `err` pulses once; write at addr 0 with 0xAABBCC. Without the macro, the same stimulus gives 0x55AABB at addr 0 and `err`=0.

Source files
------------

// File: rtl/uart_img_loader_if.sv
// UART RX FIFO read port and image RAM write port seen by the frame loader.
interface uart_img_loader_if #(
  parameter int ADDR_BITS = 13
);
  logic                 rx_empty;
  logic [7:0]           r_data;
  logic                 rd_uart;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [23:0]          mem_di;

  modport master (
    input  rx_empty, r_data,
    output rd_uart, mem_we, mem_addr, mem_di
  );

  modport slave (
    output rx_empty, r_data,
    input  rd_uart, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/uart_img_loader.sv
// Packs RX FIFO bytes into {R,G,B} pixels and writes one frame to image RAM.
// Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module uart_img_loader #(
  parameter int ADDR_BITS      = 13,
  parameter int PIXEL_COUNT    = 6767,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  uart_img_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(PIXEL_COUNT - 1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t     state;
  logic [1:0] idx;
  logic       pop;

  assign pop         = reset && (state == RECV) && !bus.rx_empty;
  assign bus.rd_uart = pop;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;
  logic          tmo;

  assign tmo = (state == RECV) && (idx != 2'd0) && bus.rx_empty &&
               (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;

  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= 2'd0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_di   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      err          <= 1'b0;
      idle_cnt     <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RECV;
            idx          <= 2'd0;
            bus.mem_addr <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        RECV: begin
          if (pop) begin
            unique case (1'b1)
              idx == 2'd0: bus.mem_di[23:16] <= bus.r_data;
              idx == 2'd1: bus.mem_di[15:8]  <= bus.r_data;
              default:     bus.mem_di[7:0]   <= bus.r_data;
            endcase
            if (idx == 2'd2) begin
              idx        <= 2'd0;
              state      <= WRITE;
              bus.mem_we <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
`ifdef LOADER_TIMEOUT_EN
          else if (tmo) begin
            idx <= 2'd0;
          end
`endif
        end
        WRITE: begin
          if (bus.mem_addr == LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            bus.mem_addr <= bus.mem_addr + 1'b1;
            state        <= RECV;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef LOADER_TIMEOUT_EN
      err <= tmo;
      // idle time only counts while a pixel is partially assembled
      if (pop || tmo || state != RECV || idx == 2'd0)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_uart_img_loader.sv
// Scoreboard bench for uart_img_loader with a 4-pixel frame.
// FIFO model feeds bytes; expected pixels are queued as stimulus is pushed.
module tb_uart_img_loader;

  localparam int AB  = 13;
  localparam int PC  = 4;
  localparam int TMO = 16;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic err;

  uart_img_loader_if #(.ADDR_BITS(AB)) bus ();

  uart_img_loader #(
    .ADDR_BITS(AB),
    .PIXEL_COUNT(PC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done),
    .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  logic [7:0]    rxq[$];
  logic [AB-1:0] expa[$];
  logic [23:0]   expd[$];
  logic          pop_req = 1'b0;
  logic          prev_rd = 1'b0;
  logic          chk_end = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_px(input int a, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
    rxq.push_back(r);
    rxq.push_back(g);
    rxq.push_back(b);
    expa.push_back(AB'(a));
    expd.push_back({r, g, b});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
    chk({tag, "_left"}, expa.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, bus.rd_uart, 0);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_di"}, bus.mem_di, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // RX FIFO model: pop what the DUT strobed last cycle, then present head
  initial begin
    bus.rx_empty = 1'b1;
    bus.r_data   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (pop_req && rxq.size() > 0) void'(rxq.pop_front());
      pop_req      = 1'b0;
      bus.rx_empty = (rxq.size() == 0);
      bus.r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end
  end

  // output monitor and scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (chk_end) begin
        chk("done_after_last", done, 1);
        chk("busy_after_last", busy, 0);
        chk_end = 1'b0;
      end
      if (bus.rd_uart && bus.rx_empty) chk("rd_on_empty", 1, 0);
      if (err) err_cnt++;
      if (bus.mem_we) begin
        chk("we_after_pop", prev_rd, 1);
        if (expa.size() == 0) begin
          chk("we_extra", 1, 0);
        end else begin
          chk("addr", bus.mem_addr, expa.pop_front());
          chk("data", bus.mem_di, expd.pop_front());
        end
        if (bus.mem_addr == AB'(PC - 1)) chk_end = 1'b1;
      end
      prev_rd = bus.rd_uart;
      pop_req = bus.rd_uart;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int viol;
    int n;
    logic [7:0] s[$];

    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;

    // first pixel, then a long empty stretch mid-frame
    pulse_start();
    push_px(0, 8'h11, 8'h22, 8'h33);
    n = 0;
    while (expa.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("px0_seen", expa.size(), 0);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.rd_uart || bus.mem_we || !busy || done) viol++;
    end
    chk("quiet_viol", viol, 0);
    push_px(1, 8'h44, 8'h55, 8'h66);
    push_px(2, 8'h77, 8'h88, 8'h99);
    push_px(3, 8'hAA, 8'hBB, 8'hCC);
    wait_done("frame1", 200);

    // full frame with trailing bytes that must stay in the FIFO
    pulse_start();
    push_px(0, 8'h00, 8'h01, 8'h02);
    push_px(1, 8'h03, 8'h04, 8'h05);
    push_px(2, 8'h06, 8'h07, 8'h08);
    push_px(3, 8'h09, 8'h0A, 8'h0B);
    rxq.push_back(8'hE0);
    rxq.push_back(8'hE1);
    rxq.push_back(8'hE2);
    wait_done("frame2", 200);
    repeat (10) @(negedge clk);
    chk("extra_kept", rxq.size(), 3);
    chk("extra_head", rxq[0], 8'hE0);
    rxq.delete();

    // reset in the middle of a pixel
    pulse_start();
    rxq.push_back(8'hDE);
    rxq.push_back(8'hAD);
    n = 0;
    while (rxq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("partial_popped", rxq.size(), 0);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    reset = 1'b1;
    pulse_start();
    push_px(0, 8'hA1, 8'hB2, 8'hC3);
    push_px(1, 8'h10, 8'h20, 8'h30);
    push_px(2, 8'h40, 8'h50, 8'h60);
    push_px(3, 8'h70, 8'h80, 8'h90);
    wait_done("frame3", 200);

    // start during a load must not restart addressing
    pulse_start();
    push_px(0, 8'h01, 8'h12, 8'h23);
    push_px(1, 8'h34, 8'h45, 8'h56);
    push_px(2, 8'h67, 8'h78, 8'h89);
    push_px(3, 8'h9A, 8'hAB, 8'hBC);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("frame4", 200);
    chk("err_before_tmo", err_cnt, 0);

    // lone byte followed by an idle gap
    pulse_start();
    rxq.push_back(8'h55);
    n = 0;
    while (!bus.rd_uart && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lone_pop", bus.rd_uart, 1);
    repeat (TMO) @(negedge clk);
    s.delete();
`ifndef LOADER_TIMEOUT_EN
    s.push_back(8'h55);
`endif
    s.push_back(8'hAA);
    s.push_back(8'hBB);
    s.push_back(8'hCC);
    rxq.push_back(8'hAA);
    rxq.push_back(8'hBB);
    rxq.push_back(8'hCC);
    for (int i = 0; i < 9; i++) begin
      rxq.push_back(8'(8'h40 + i));
      s.push_back(8'(8'h40 + i));
    end
    for (int p = 0; p < PC; p++) begin
      expa.push_back(AB'(p));
      expd.push_back({s[3*p], s[3*p+1], s[3*p+2]});
    end
    wait_done("frame5", 300);
`ifdef LOADER_TIMEOUT_EN
    chk("err_pulses", err_cnt, 1);
`else
    chk("err_pulses", err_cnt, 0);
`endif
    rxq.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
